// File: rtl/rv_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// rv_ctrl_pkg
// Shared definitions for the decoder -> pipeline control interface.
//   CTRL_W          : width of the control bundle
//   CTRL_*          : bit offsets inside the bundle (MSB first):
//                     {RegWrite, ResultSrc[1:0], MemRead, MemWrite, ALUOp[1:0],
//                      ALUSrc, ALUASrc, Branch, Jump[1:0]}
//   res_src_e       : ResultSrc encodings
//   FWD_*           : EX operand forwarding select values
// ----------------------------------------------------------------------------
package rv_ctrl_pkg;

   localparam int CTRL_W = 12;

   // Offsets of single bits, or the LSB of multi-bit fields.
   localparam int CTRL_REGWRITE = 11;
   localparam int CTRL_RESSRC   = 9;   // [10:9]
   localparam int CTRL_MEMREAD  = 8;
   localparam int CTRL_MEMWRITE = 7;
   localparam int CTRL_ALUOP    = 5;   // [6:5]
   localparam int CTRL_ALUSRC   = 4;
   localparam int CTRL_ALUASRC  = 3;
   localparam int CTRL_BRANCH   = 2;
   localparam int CTRL_JUMP     = 0;   // [1:0]

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_IMM = 2'b10,
      RES_PC4 = 2'b11
   } res_src_e;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   function automatic res_src_e res_src(input logic [CTRL_W-1:0] c);
      return res_src_e'(c[CTRL_RESSRC +: 2]);
   endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// ----------------------------------------------------------------------------
// ctrl_stage_reg
// One pipeline stage register: a valid bit plus a payload (control bundle,
// destination and, for EX, the source register fields).
//   clk, rst_n : clock, asynchronous active-low reset (clears everything)
//   hold_i     : keep current contents (takes precedence over bubble_i)
//   bubble_i   : load an empty slot (valid=0, payload=0)
//   valid_i    : incoming valid
//   data_i     : incoming payload
//   valid_o    : registered valid
//   data_o     : registered payload
// ----------------------------------------------------------------------------
module ctrl_stage_reg #(
   parameter int DW = 17
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          hold_i,
   input  logic          bubble_i,
   input  logic          valid_i,
   input  logic [DW-1:0] data_i,
   output logic          valid_o,
   output logic [DW-1:0] data_o
);

   logic          valid_d, valid_q;
   logic [DW-1:0] data_d,  data_q;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (!hold_i) begin
         if (bubble_i) begin
            valid_d = 1'b0;
            data_d  = '0;
         end else begin
            valid_d = valid_i;
            data_d  = data_i;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/ctrl_pipeline.sv
// ----------------------------------------------------------------------------
// ctrl_pipeline
// Carries the decoded control bundle from ID through EX, MEM and WB, and
// produces the hazard controls (load-use stall, redirect flush, data-memory
// freeze) and the EX operand forwarding selects for a 5-stage RV32I core.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   id_valid, id_ctrl          : ID instruction present, its control bundle
//   id_rs1, id_rs2, id_rd      : ID register fields
//   ex_redirect                : branch taken / jump resolved in EX
//   mem_ready                  : data memory completes this cycle
//   stall_id, flush_id         : hold / squash the IF/ID register
//   {ex,mem,wb}_valid/ctrl/rd  : per-stage occupancy, bundle, destination
//   fwd_a, fwd_b               : EX operand select (00 RF, 01 WB, 10 MEM)
// Optional feature macro CTRL_PIPE_PERF_EN adds saturating stall_cycles and
// flush_cycles counters (CNT_W wide).
// ----------------------------------------------------------------------------
module ctrl_pipeline
   import rv_ctrl_pkg::*;
#(
   parameter int RA_W   = 5,
   parameter int CTRL_W = rv_ctrl_pkg::CTRL_W,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [RA_W-1:0]   id_rs1,
   input  logic [RA_W-1:0]   id_rs2,
   input  logic [RA_W-1:0]   id_rd,
   input  logic              ex_redirect,
   input  logic              mem_ready,
   output logic              stall_id,
   output logic              flush_id,
   output logic              ex_valid,
   output logic              mem_valid,
   output logic              wb_valid,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [CTRL_W-1:0] mem_ctrl,
   output logic [CTRL_W-1:0] wb_ctrl,
   output logic [RA_W-1:0]   ex_rd,
   output logic [RA_W-1:0]   mem_rd,
   output logic [RA_W-1:0]   wb_rd,
`ifdef CTRL_PIPE_PERF_EN
   output logic [CNT_W-1:0]  stall_cycles,
   output logic [CNT_W-1:0]  flush_cycles,
`endif
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b
);

   localparam int EX_DW = CTRL_W + 3 * RA_W;
   localparam int WB_DW = CTRL_W + RA_W;

   logic              freeze, redirect, load_use;
   logic [CTRL_W-1:0] id_ctrl_in;
   logic [RA_W-1:0]   ex_rs1, ex_rs2;
   logic [EX_DW-1:0]  ex_data;
   logic [WB_DW-1:0]  mem_data, wb_data;

   // A write to x0 is meaningless; dropping RegWrite here keeps x0 out of
   // every forwarding and writeback decision downstream.
   always_comb begin
      id_ctrl_in = id_ctrl;
      if (id_rd == '0) id_ctrl_in[CTRL_REGWRITE] = 1'b0;
   end

   // Priority: freeze > redirect > load_use. rs2 is compared even for
   // formats without rs2; the occasional false stall is harmless.
   assign freeze   = mem_valid & (mem_ctrl[CTRL_MEMREAD] | mem_ctrl[CTRL_MEMWRITE])
                     & ~mem_ready;
   assign redirect = ~freeze & ex_redirect;
   assign load_use = ~freeze & ~ex_redirect & ex_valid & ex_ctrl[CTRL_MEMREAD]
                     & (ex_rd != '0) & id_valid
                     & ((ex_rd == id_rs1) | (ex_rd == id_rs2));

   assign stall_id = freeze | load_use;
   assign flush_id = redirect;

   ctrl_stage_reg #(.DW(EX_DW)) u_ex (
      .clk      (clk),
      .rst_n    (rst_n),
      .hold_i   (freeze),
      .bubble_i (redirect | load_use | ~id_valid),
      .valid_i  (id_valid),
      .data_i   ({id_ctrl_in, id_rd, id_rs1, id_rs2}),
      .valid_o  (ex_valid),
      .data_o   (ex_data)
   );
   assign {ex_ctrl, ex_rd, ex_rs1, ex_rs2} = ex_data;

   ctrl_stage_reg #(.DW(WB_DW)) u_mem (
      .clk      (clk),
      .rst_n    (rst_n),
      .hold_i   (freeze),
      .bubble_i (1'b0),
      .valid_i  (ex_valid),
      .data_i   ({ex_ctrl, ex_rd}),
      .valid_o  (mem_valid),
      .data_o   (mem_data)
   );
   assign {mem_ctrl, mem_rd} = mem_data;

   // While MEM is frozen WB takes a bubble so the frozen instruction
   // retires exactly once, when the freeze lifts.
   ctrl_stage_reg #(.DW(WB_DW)) u_wb (
      .clk      (clk),
      .rst_n    (rst_n),
      .hold_i   (1'b0),
      .bubble_i (freeze),
      .valid_i  (mem_valid),
      .data_i   ({mem_ctrl, mem_rd}),
      .valid_o  (wb_valid),
      .data_o   (wb_data)
   );
   assign {wb_ctrl, wb_rd} = wb_data;

   // A load in MEM has no data yet, so it never forwards; the load-use
   // stall ensures the consumer sees it from WB instead.
   logic mem_fwd_ok, wb_fwd_ok;
   assign mem_fwd_ok = mem_valid & mem_ctrl[CTRL_REGWRITE] & (mem_rd != '0)
                       & (res_src(mem_ctrl) != RES_MEM);
   assign wb_fwd_ok  = wb_valid & wb_ctrl[CTRL_REGWRITE] & (wb_rd != '0);

   always_comb begin
      fwd_a = FWD_RF;
      fwd_b = FWD_RF;
      if (mem_fwd_ok && mem_rd == ex_rs1)     fwd_a = FWD_MEM;
      else if (wb_fwd_ok && wb_rd == ex_rs1)  fwd_a = FWD_WB;
      if (mem_fwd_ok && mem_rd == ex_rs2)     fwd_b = FWD_MEM;
      else if (wb_fwd_ok && wb_rd == ex_rs2)  fwd_b = FWD_WB;
   end

`ifdef CTRL_PIPE_PERF_EN
   logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_id && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
      if (flush_id && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cycles = stall_cnt_q;
   assign flush_cycles = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ctrl_pipeline.sv
// ----------------------------------------------------------------------------
// tb_ctrl_pipeline
// Directed scenarios followed by randomized traffic, checked against a
// slot-level reference model of the ID->EX->MEM->WB control pipeline.
// ----------------------------------------------------------------------------
module tb_ctrl_pipeline;

   localparam logic [11:0] C_ADD  = 12'h840;
   localparam logic [11:0] C_LW   = 12'hB10;
   localparam logic [11:0] C_SW   = 12'h090;
   localparam logic [11:0] C_BEQ  = 12'h024;
   localparam logic [11:0] C_ADDI = 12'h850;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        id_valid = 1'b0;
   logic [11:0] id_ctrl = '0;
   logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
   logic        ex_redirect = 1'b0;
   logic        mem_ready = 1'b1;
   logic        stall_id, flush_id;
   logic        ex_valid, mem_valid, wb_valid;
   logic [11:0] ex_ctrl, mem_ctrl, wb_ctrl;
   logic [4:0]  ex_rd, mem_rd, wb_rd;
   logic [1:0]  fwd_a, fwd_b;
`ifdef CTRL_PIPE_PERF_EN
   logic [31:0] stall_cycles, flush_cycles;
`endif

   ctrl_pipeline dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .id_valid     (id_valid),
      .id_ctrl      (id_ctrl),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_rd        (id_rd),
      .ex_redirect  (ex_redirect),
      .mem_ready    (mem_ready),
      .stall_id     (stall_id),
      .flush_id     (flush_id),
      .ex_valid     (ex_valid),
      .mem_valid    (mem_valid),
      .wb_valid     (wb_valid),
      .ex_ctrl      (ex_ctrl),
      .mem_ctrl     (mem_ctrl),
      .wb_ctrl      (wb_ctrl),
      .ex_rd        (ex_rd),
      .mem_rd       (mem_rd),
      .wb_rd        (wb_rd),
`ifdef CTRL_PIPE_PERF_EN
      .stall_cycles (stall_cycles),
      .flush_cycles (flush_cycles),
`endif
      .fwd_a        (fwd_a),
      .fwd_b        (fwd_b)
   );

   // ---------------- scoreboard ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Each stage is an "instruction slot"; the model moves whole slots
   // according to the per-cycle priority rules.
   typedef struct packed {
      logic        v;
      logic [11:0] c;
      logic [4:0]  rd, rs1, rs2;
   } slot_t;

   slot_t m_ex, m_mem, m_wb;
   logic [31:0] m_stall_cnt, m_flush_cnt;
   logic obs_stall, obs_flush;

   function automatic logic m_freeze(input logic mrdy);
      return m_mem.v && (m_mem.c[8] || m_mem.c[7]) && !mrdy;
   endfunction

   function automatic logic m_load_use(input logic v, input logic [4:0] r1, input logic [4:0] r2);
      return m_ex.v && m_ex.c[8] && m_ex.rd != 0 && v && (m_ex.rd == r1 || m_ex.rd == r2);
   endfunction

   function automatic logic [1:0] m_fwd(input logic [4:0] rs);
      // a load still in MEM cannot supply data
      if (m_mem.v && m_mem.c[11] && m_mem.c[10:9] != 2'b01 && m_mem.rd == rs && rs != 0) return 2'b10;
      if (m_wb.v && m_wb.c[11] && m_wb.rd == rs && rs != 0) return 2'b01;
      return 2'b00;
   endfunction

   function automatic slot_t empty_slot();
      slot_t s;
      s = '0;
      return s;
   endfunction

   task automatic model_reset();
      m_ex = empty_slot(); m_mem = empty_slot(); m_wb = empty_slot();
      m_stall_cnt = 0; m_flush_cnt = 0;
   endtask

   task automatic check_regs(input string pfx);
      check_eq({pfx, ".ex_valid"},  {31'd0, ex_valid},  {31'd0, m_ex.v});
      check_eq({pfx, ".ex_ctrl"},   {20'd0, ex_ctrl},   {20'd0, m_ex.c});
      check_eq({pfx, ".ex_rd"},     {27'd0, ex_rd},     {27'd0, m_ex.rd});
      check_eq({pfx, ".mem_valid"}, {31'd0, mem_valid}, {31'd0, m_mem.v});
      check_eq({pfx, ".mem_ctrl"},  {20'd0, mem_ctrl},  {20'd0, m_mem.c});
      check_eq({pfx, ".mem_rd"},    {27'd0, mem_rd},    {27'd0, m_mem.rd});
      check_eq({pfx, ".wb_valid"},  {31'd0, wb_valid},  {31'd0, m_wb.v});
      check_eq({pfx, ".wb_ctrl"},   {20'd0, wb_ctrl},   {20'd0, m_wb.c});
      check_eq({pfx, ".wb_rd"},     {27'd0, wb_rd},     {27'd0, m_wb.rd});
      check_eq({pfx, ".fwd_a"},     {30'd0, fwd_a},     {30'd0, m_fwd(m_ex.rs1)});
      check_eq({pfx, ".fwd_b"},     {30'd0, fwd_b},     {30'd0, m_fwd(m_ex.rs2)});
`ifdef CTRL_PIPE_PERF_EN
      check_eq({pfx, ".stall_cycles"}, stall_cycles, m_stall_cnt);
      check_eq({pfx, ".flush_cycles"}, flush_cycles, m_flush_cnt);
`endif
   endtask

   // ---------------- driver ----------------
   // One clock cycle: drive at negedge, check hazard outputs, clock, advance
   // the model, check registered state.
   task automatic step(input logic v, input logic [11:0] c, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] rd,
                       input logic rdr, input logic mrdy);
      logic  fz, lu, e_stall, e_flush;
      slot_t nxt;
      @(negedge clk);
      id_valid = v; id_ctrl = c; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
      ex_redirect = rdr; mem_ready = mrdy;
      #1;
      fz = m_freeze(mrdy);
      lu = m_load_use(v, r1, r2);
      e_stall = fz || (!rdr && lu);
      e_flush = !fz && rdr;
      obs_stall = stall_id;
      obs_flush = flush_id;
      check_eq("stall_id", {31'd0, stall_id}, {31'd0, e_stall});
      check_eq("flush_id", {31'd0, flush_id}, {31'd0, e_flush});
      @(posedge clk);
      nxt = empty_slot();
      if (v) begin
         nxt.v = 1'b1; nxt.c = c; nxt.rd = rd; nxt.rs1 = r1; nxt.rs2 = r2;
         if (rd == 0) nxt.c[11] = 1'b0;
      end
      if (fz) begin
         m_wb = empty_slot();
      end else begin
         m_wb  = m_mem;
         m_mem = m_ex;
         m_ex  = (rdr || lu) ? empty_slot() : nxt;
      end
      if (e_stall && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
      if (e_flush && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt++;
      #1;
      check_regs("cyc");
   endtask

   task automatic idle(input logic mrdy);
      step(1'b0, 12'h000, 5'd0, 5'd0, 5'd0, 1'b0, mrdy);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic        hv, hr, prev_stall, prev_fz;
      logic [11:0] hc;
      logic [4:0]  h1, h2, hd;
      logic        mr;

      model_reset();
      #22;
      check_regs("reset");
      check_eq("reset.stall_id", {31'd0, stall_id}, 32'd0);
      check_eq("reset.flush_id", {31'd0, flush_id}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // add x5 ; sub x6,x5,x1 -> forward from MEM
      step(1, C_ADD, 5'd1, 5'd2, 5'd5, 0, 1);
      step(1, C_ADD, 5'd5, 5'd1, 5'd6, 0, 1);
      check_eq("t1.no_stall", {31'd0, obs_stall}, 32'd0);
      check_eq("t1.fwd_a_mem", {30'd0, fwd_a}, 32'd2);
      idle(1);
      check_eq("t1.wb_rd", {27'd0, wb_rd}, 32'd5);
      check_eq("t1.wb_valid", {31'd0, wb_valid}, 32'd1);

      // lw x5 ; add x6,x5,x2 -> one stall, then forward from WB
      step(1, C_LW, 5'd1, 5'd0, 5'd5, 0, 1);
      step(1, C_ADD, 5'd5, 5'd2, 5'd6, 0, 1);
      check_eq("t2.stall", {31'd0, obs_stall}, 32'd1);
      check_eq("t2.ex_bubble", {31'd0, ex_valid}, 32'd0);
      step(1, C_ADD, 5'd5, 5'd2, 5'd6, 0, 1);
      check_eq("t2.stall_once", {31'd0, obs_stall}, 32'd0);
      check_eq("t2.fwd_a_wb", {30'd0, fwd_a}, 32'd1);

      // beq in EX with redirect: flush ID
      step(1, C_BEQ, 5'd7, 5'd8, 5'd0, 0, 1);
      step(1, C_ADD, 5'd5, 5'd1, 5'd9, 1, 1);
      check_eq("t3.flush", {31'd0, obs_flush}, 32'd1);
      check_eq("t3.no_stall", {31'd0, obs_stall}, 32'd0);
      check_eq("t3.ex_bubble", {31'd0, ex_valid}, 32'd0);
      // load-use coinciding with redirect: redirect wins, no stall
      step(1, C_LW, 5'd1, 5'd0, 5'd5, 0, 1);
      step(1, C_ADD, 5'd5, 5'd1, 5'd6, 1, 1);
      check_eq("t3b.flush", {31'd0, obs_flush}, 32'd1);
      check_eq("t3b.no_stall", {31'd0, obs_stall}, 32'd0);

      // sw frozen in MEM for 3 cycles
      step(1, C_SW, 5'd1, 5'd2, 5'd0, 0, 1);
      idle(1);
      for (int i = 0; i < 3; i++) begin
         idle(0);
         check_eq("t4.stall", {31'd0, obs_stall}, 32'd1);
         check_eq("t4.wb_bubble", {31'd0, wb_valid}, 32'd0);
         check_eq("t4.mem_hold", {20'd0, mem_ctrl}, {20'd0, C_SW});
      end
      idle(1);
      check_eq("t4.sw_retire", {20'd0, wb_ctrl}, {20'd0, C_SW});
      idle(1);
      check_eq("t4.sw_once", {31'd0, wb_valid}, 32'd0);

      // addi x0,x0,1 ; add x7,x0,x0
      step(1, C_ADDI, 5'd0, 5'd0, 5'd0, 0, 1);
      check_eq("t5.x0_regwrite", {31'd0, ex_ctrl[11]}, 32'd0);
      step(1, C_ADD, 5'd0, 5'd0, 5'd7, 0, 1);
      check_eq("t5.no_fwd_x0", {30'd0, fwd_a}, 32'd0);

      // reset mid-stream with a lw in MEM
      step(1, C_LW, 5'd3, 5'd0, 5'd4, 0, 1);
      idle(1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("t6.ex_valid",  {31'd0, ex_valid},  32'd0);
      check_eq("t6.mem_valid", {31'd0, mem_valid}, 32'd0);
      check_eq("t6.wb_valid",  {31'd0, wb_valid},  32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step(1, C_ADD, 5'd1, 5'd2, 5'd3, 0, 1);
      check_eq("t6.wb_regwrite", {31'd0, wb_ctrl[11]}, 32'd0);

      // randomized traffic; upstream holds ID while stalled and keeps a
      // redirect asserted while a freeze holds EX
      prev_stall = 0; prev_fz = 0;
      hv = 0; hc = '0; h1 = '0; h2 = '0; hd = '0; hr = 0;
      for (int n = 0; n < 3000; n++) begin
         if (!prev_stall) begin
            hv = ($urandom_range(0, 9) < 8);
            case ($urandom_range(0, 4))
               0: hc = C_LW;
               1: hc = C_SW;
               2: hc = C_BEQ;
               3: hc = C_ADD;
               default: hc = 12'($urandom);
            endcase
            h1 = 5'($urandom_range(0, 3));
            h2 = 5'($urandom_range(0, 3));
            hd = 5'($urandom_range(0, 3));
         end
         if (!(prev_fz && hr)) hr = ($urandom_range(0, 9) == 0);
         mr = ($urandom_range(0, 9) < 7);
         prev_fz = m_freeze(mr);
         step(hv, hc, h1, h2, hd, hr, mr);
         prev_stall = obs_stall && !prev_fz ? 1'b1 : obs_stall;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ctrl_pipeline.md
Name: ctrl_pipeline

Overview:
- Consumer end of the decoder's control-signal interface.
- Takes the 12-bit control bundle produced in ID and carries it through EX, MEM and WB stage registers.
- Detects load-use hazards, applies branch/jump redirect flushes and data-memory back-pressure freezes.
- Generates EX operand forwarding selects for the 5-stage RV32I pipeline.

Parameters:
- RA_W, 5, register-address width.
- CTRL_W, 12, control bundle width: {RegWrite, ResultSrc[1:0], MemRead, MemWrite, ALUOp[1:0], ALUSrc, ALUASrc, Branch, Jump[1:0]}, MSB first.
- CNT_W, 32, performance counter width (optional feature only).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_ctrl  in  CTRL_W  decoded control bundle.
- id_rs1, id_rs2, id_rd  in  RA_W  ID register fields.
- ex_redirect  in  1  branch taken or JAL/JALR resolved in EX.
- mem_ready  in  1  data memory accepts/returns this cycle.
- stall_id  out  1  hold PC and IF/ID register.
- flush_id  out  1  squash IF/ID contents.
- ex_valid, mem_valid, wb_valid  out  1  stage occupancy.
- ex_ctrl, mem_ctrl, wb_ctrl  out  CTRL_W  per-stage bundles.
- ex_rd, mem_rd, wb_rd  out  RA_W  per-stage destinations.
- fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 01 WB, 10 MEM.

Behaviour:
- Reset (async, rst_n=0): all valids 0, all ctrl/rd registers 0, stall_id=0, flush_id=0, fwd=00. Counters, if present, are 0.
- Reset mid-operation discards all in-flight bundles. No write enables may be asserted in the cycle after release.
- Bubble: valid=0 and ctrl=0. Downstream sees RegWrite=MemRead=MemWrite=Branch=Jump=0.
- freeze = mem_valid & (mem MemRead | mem MemWrite) & ~mem_ready.
- load_use = ex_valid & ex MemRead & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2).
  - Rs2 is compared even for I-type. The false stall is accepted.
- Priority per cycle: freeze > redirect > load_use > normal advance.
- freeze:
  - EX and MEM hold.
  - WB loads a bubble, so the MEM instruction retires once.
  - stall_id=1, flush_id=0.
  - A pending ex_redirect is not acted on until the freeze ends; upstream keeps it asserted while EX holds.
- redirect (no freeze):
  - flush_id=1, stall_id=0.
  - EX loads a bubble; the ID instruction is squashed.
  - EX→MEM→WB advance normally.
- load_use (no freeze, no redirect):
  - stall_id=1.
  - EX loads a bubble; MEM and WB advance.
  - Exactly one stall cycle per load-use pair.
- Normal: EX←ID (valid=id_valid), MEM←EX, WB←MEM. Latency ID→WB is 3 cycles.
- On entry to EX, RegWrite is forced to 0 when id_rd==0.
- Forwarding, computed combinationally from registered ex_rs1/ex_rs2:
  - fwd_a=10 if mem_valid & mem RegWrite & mem_rd==ex_rs1 & mem_rd!=0.
  - Otherwise 01 under the same test on WB.
  - Otherwise 00. Same rules for fwd_b with ex_rs2.
  - MEM has precedence over WB.
- MEM-stage loads are never forwarded: mem ResultSrc==01 excludes the MEM match. The load_use stall guarantees correctness.
- Simultaneous load_use and redirect: redirect wins. There is no stall, because the dependent instruction is squashed.

Optional Feature:
- Macro CTRL_PIPE_PERF_EN.
- Defined:
  - Adds outputs stall_cycles and flush_cycles, each CNT_W.
  - stall_cycles increments each cycle stall_id=1; flush_cycles increments each cycle flush_id=1.
  - Both saturate at all-ones; both reset to 0.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package rv_ctrl_pkg:
  - CTRL_W.
  - Bundle bit-offset constants: CTRL_REGWRITE, CTRL_RESSRC, CTRL_MEMREAD, CTRL_MEMWRITE, CTRL_ALUOP, CTRL_ALUSRC, CTRL_ALUASRC, CTRL_BRANCH, CTRL_JUMP.
  - ResultSrc encodings: 00 ALU, 01 MEM, 10 IMM, 11 PC+4.
  - FWD_* select constants.
- One sub-module, ctrl_stage_reg: valid+ctrl+rd(+rs) register with hold and bubble inputs, instantiated three times.

Test Plan:
- add x5 then sub x6,x5,x1 with no hazards → sub in EX with fwd_a=10; one cycle later WB carries x5; no stall.
- lw x5,0(x1) then add x6,x5,x2 → stall_id=1 for exactly 1 cycle, EX bubble; add in EX sees fwd_a=01.
- beq in EX with ex_redirect=1 while lw-dependent instruction is in ID → flush_id=1, stall_id=0, next ex_valid=0.
- sw in MEM with mem_ready=0 for 3 cycles → EX/MEM hold, stall_id=1 for 3 cycles, wb_valid=0 for 3 cycles; sw reaches WB once.
- addi x0,x0,1 → ex_ctrl RegWrite=0; no forwarding match on x0.
- rst_n pulsed low mid-stream with a lw in MEM → all valids 0 asynchronously; wb_ctrl RegWrite=0 on the first post-reset edge.
